// File: rtl/lc2k_control_fsm.sv
// lc2k_control_fsm: multicycle control unit for the LC2K processor.
//
// Latches the opcode of the fetched instruction and steps each instruction
// through FETCH/EXEC/MEM/WB. Every datapath select and strobe is decoded from
// (state, latched opcode), so the selects stay stable for the whole instruction.
//
// Optional feature macro: LC2K_RETIRE_COUNT_EN
//   defined     -> instr_count counts retired instructions (wraps modulo 2^(CNT_LEN+1))
//   not defined -> instr_count is tied to 0 and no counter flops are built
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   EN            global enable; low freezes state/IR/counter and masks pc_we/rf_en/dm_en
//   instr         instruction word at the current PC (only bits [24:22] are used)
//   alu_eq        ALU equality flag, steers beq
//   mem_ready     data memory completes its access this cycle
//   pc_we, pc_swap, pc_jalr                   PC load strobe and source selects
//   rf_dest_mux, rf_data_mux, rf_jalr_mux     register file write selects
//   rf_en                                     register file write strobe
//   alu_in, alu_op                            ALU operand B select and operation
//   dm_en, dm_rw                              data memory request and direction
//   halted, state                             status: HALT reached, current FSM state
//   instr_count                               retired-instruction count

module lc2k_control_fsm #(
  parameter int unsigned DATA_LEN = 31,
  parameter int unsigned CNT_LEN  = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_LEN:0] instr,
  input  logic              alu_eq,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              pc_swap,
  output logic              pc_jalr,
  output logic              rf_dest_mux,
  output logic              rf_data_mux,
  output logic              rf_jalr_mux,
  output logic              rf_en,
  output logic              alu_in,
  output logic              alu_op,
  output logic              dm_en,
  output logic              dm_rw,
  output logic              halted,
  output logic [2:0]        state,
  output logic [CNT_LEN:0]  instr_count
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StExec  = 3'd1,
    StMem   = 3'd2,
    StWb    = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpNor  = 3'b001;
  localparam logic [2:0] OpLw   = 3'b010;
  localparam logic [2:0] OpSw   = 3'b011;
  localparam logic [2:0] OpBeq  = 3'b100;
  localparam logic [2:0] OpJalr = 3'b101;
  localparam logic [2:0] OpHalt = 3'b110;
  localparam logic [2:0] OpNoop = 3'b111;

  state_e     state_q, state_d;
  // Only the opcode field of the IR influences control, so only it is stored.
  logic [2:0] ir_op_q, ir_op_d;

  // Ungated strobes; EN masks them below.
  logic pc_we_raw, rf_en_raw, dm_en_raw;

  // Register fields and the upper bits are consumed by the datapath, not here.
  logic unused_instr;
  assign unused_instr = ^{instr[DATA_LEN:25], instr[21:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StFetch;
      ir_op_q <= 3'b000;
    end else begin
      state_q <= state_d;
      ir_op_q <= ir_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_op_d     = ir_op_q;
    pc_we_raw   = 1'b0;
    rf_en_raw   = 1'b0;
    dm_en_raw   = 1'b0;
    pc_swap     = 1'b0;
    pc_jalr     = 1'b0;
    rf_dest_mux = 1'b0;
    rf_data_mux = 1'b0;
    rf_jalr_mux = 1'b0;
    alu_in      = 1'b0;
    alu_op      = 1'b0;
    dm_rw       = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      StFetch: begin
        ir_op_d = instr[24:22];
        state_d = StExec;
      end

      StExec: begin
        unique case (ir_op_q)
          OpAdd: begin
            alu_in  = 1'b1;
            state_d = StWb;
          end
          OpNor: begin
            alu_in  = 1'b1;
            alu_op  = 1'b1;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            state_d = StMem;
          end
          OpBeq: begin
            alu_in    = 1'b1;
            pc_swap   = alu_eq;
            pc_we_raw = 1'b1;
            state_d   = StFetch;
          end
          OpJalr: begin
            pc_jalr     = 1'b1;
            rf_en_raw   = 1'b1;
            rf_jalr_mux = 1'b1;
            rf_dest_mux = 1'b1;
            pc_we_raw   = 1'b1;
            state_d     = StFetch;
          end
          OpHalt: begin
            pc_we_raw = 1'b1;
            state_d   = StHalt;
          end
          OpNoop: begin
            pc_we_raw = 1'b1;
            state_d   = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end

      // Address selects (alu_in=0, alu_op=0) are the defaults and stay held here.
      StMem: begin
        dm_en_raw = 1'b1;
        dm_rw     = (ir_op_q == OpSw);
        if (mem_ready) begin
          if (ir_op_q == OpSw) begin
            pc_we_raw = 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        rf_en_raw = 1'b1;
        pc_we_raw = 1'b1;
        state_d   = StFetch;
        if (ir_op_q == OpLw) begin
          rf_data_mux = 1'b1;
          rf_dest_mux = 1'b1;
        end else begin
          // Keep the ALU configured so alu_out stays valid during the write.
          alu_in = 1'b1;
          alu_op = (ir_op_q == OpNor);
        end
      end

      StHalt: begin
        halted = 1'b1;
      end

      default: state_d = StFetch;
    endcase

    if (!EN) begin
      state_d = state_q;
      ir_op_d = ir_op_q;
    end
  end

  assign pc_we = pc_we_raw & EN;
  assign rf_en = rf_en_raw & EN;
  assign dm_en = dm_en_raw & EN;
  assign state = state_q;

`ifdef LC2K_RETIRE_COUNT_EN
  logic [CNT_LEN:0] count_q;

  // Every retiring cycle is exactly the cycle that asserts pc_we.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (pc_we) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule
